uart_send: RTL and testbench
============================

UART_SEND -- requirements
Module: uart_send

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the sys_clk frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115_200, meaning the line baud rate.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even; any other value SHALL behave as 0.
REQ-004 sys_clk  input  1  single clock; all logic on its rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 uart_en  input  1  send request level; a send starts only on its rising edge.
REQ-007 uart_din  input  8  byte to transmit, sampled when the send starts.
REQ-008 uart_tx_busy  output  1  high while a frame is on the line.
REQ-009 uart_txd  output  1  serial line, idle high.

Function
REQ-010 SHALL compute BPS_CNT = CLK_FREQ / UART_BPS using integer truncation; every bit period SHALL last exactly BPS_CNT clocks.
REQ-011 SHALL register uart_en through two flops, en_d0 then en_d1; the start flag SHALL equal en_d0 AND NOT en_d1.
REQ-012 SHALL keep a level-high uart_en from triggering more than one frame; a new frame needs a fresh 0->1 transition.
REQ-013 Start acceptance: the edge where uart_en is first sampled high is edge k; if uart_tx_busy = 0 at edge k+1, the block SHALL do all of the following at edge k+1:
- latch uart_din
- set uart_tx_busy = 1
- drive uart_txd = 0 (start bit)
REQ-014 A start flag seen while uart_tx_busy = 1 SHALL be dropped; it is not queued, and the frame in progress is unaffected.
REQ-015 A start flag at the same edge where busy falls SHALL be dropped.
REQ-016 uart_din changes after latching SHALL NOT affect the frame in progress.
REQ-017 State machine states are IDLE, START, DATA, PARITY, STOP.
REQ-018 Transitions SHALL be as follows, each bit state lasting BPS_CNT clocks:
- IDLE -> START on an accepted start flag
- START -> DATA
- DATA -> PARITY after bit 7 if PARITY is 1 or 2, else DATA -> STOP
- PARITY -> STOP
- STOP -> IDLE
REQ-019 DATA SHALL send bits LSB first, bit 0 through bit 7.
REQ-020 The parity bit SHALL be XOR of the 8 data bits for even, and its inverse for odd.
REQ-021 The stop bit SHALL be 1.
REQ-022 A bit counter SHALL count 0..BPS_CNT-1 and wrap to 0 at each bit boundary; a data index SHALL count 0..7.
REQ-023 uart_txd SHALL be driven from a register (glitch-free) and SHALL be 1 in IDLE.
REQ-024 uart_tx_busy SHALL fall at edge k+1+N*BPS_CNT, where N = 10 with no parity and 11 with parity; uart_txd SHALL stay 1 from that point.
REQ-025 Back-to-back frames: a new rising edge of uart_en that yields an accepted start flag after busy has fallen SHALL start a new frame with no extra idle time beyond REQ-013 latency.

Reset
REQ-026 While sys_rst_n = 0, the block SHALL asynchronously hold:
- uart_txd = 1
- uart_tx_busy = 0
- en_d0 = en_d1 = 0
- state = IDLE
- counters = 0
- latched data = 0
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, with the line returning high, and no partial frame SHALL resume after release.
REQ-028 After release, a uart_en already high SHALL be seen as a rising edge (en_d1 = 0) and SHALL start one frame.

Verification (CLK_FREQ = 1_000_000, UART_BPS = 100_000, so BPS_CNT = 10)
REQ-029 PARITY = 0, uart_din = 8'h55, single uart_en pulse: txd falls at k+1, then shows 1,0,1,0,1,0,1,0 for 10 clocks each, then stop; busy falls at k+101.
REQ-030 PARITY = 2, uart_din = 8'h07: parity bit = 1; PARITY = 1, same data: parity bit = 0; busy high for 110 clocks in both cases.
REQ-031 uart_en held high for 300 clocks with uart_din = 8'hA3: exactly one frame is sent, carrying A3, and txd stays 1 afterwards.
REQ-032 Second uart_en rising edge at clock 40 of a frame with uart_din = 8'hFF: it is ignored; the first frame completes unchanged; no second frame follows.
REQ-033 sys_rst_n pulsed low during data bit 3: txd = 1 and busy = 0 within the same cycle; after release with uart_en low, the line stays idle.
REQ-034 Two frames, 8'h01 then 8'h80, with the second uart_en edge issued right after busy falls: both are received correctly by a reference UART receiver model.

Source files
------------

// File: rtl/uart_send.sv
// uart_send -- 8-bit UART transmitter with optional parity.
//
// A frame is sent for each fresh rising edge of uart_en. The frame is a start bit
// (0), the data bits LSB first, an optional parity bit and a stop bit (1). Every
// bit lasts CLK_FREQ / UART_BPS clocks.
//
// Parameters:
//   CLK_FREQ  sys_clk frequency in Hz
//   UART_BPS  line baud rate
//   PARITY    0 = none, 1 = odd, 2 = even (any other value behaves as none)
//
// Ports:
//   sys_clk       in   clock, all logic on its rising edge
//   sys_rst_n     in   asynchronous active-low reset
//   uart_en       in   send request; only a 0->1 transition starts a frame
//   uart_din[7:0] in   byte to send, latched when the frame starts
//   uart_tx_busy  out  high while a frame is on the line
//   uart_txd      out  registered serial line, idle high
module uart_send #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115_200,
    parameter int PARITY   = 0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_en,
    input  logic [7:0] uart_din,
    output logic       uart_tx_busy,
    output logic       uart_txd
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
    localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam logic PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             txd_q, txd_d;
    logic             en_d0_q, en_d0_d;
    logic             en_d1_q, en_d1_d;

    logic             start_flag;
    logic             bit_end;
    logic [2:0]       idx_inc;
    logic             par_bit;

    assign start_flag = en_d0_q & ~en_d1_q;
    assign bit_end    = (cnt_q == CNT_MAX);
    assign idx_inc    = idx_q + 3'd1;
    // Even parity is the XOR of the data bits; odd parity is its inverse.
    assign par_bit    = (^data_q) ^ PAR_ODD;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        busy_d  = busy_q;
        txd_d   = txd_q;
        en_d0_d = uart_en;
        en_d1_d = en_d0_q;

        case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                idx_d  = '0;
                // Start flags are accepted only here, so a flag raised while
                // busy (including on the edge where busy falls) is dropped.
                if (start_flag) begin
                    state_d = ST_START;
                    data_d  = uart_din;
                    busy_d  = 1'b1;
                    txd_d   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                    txd_d   = data_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
                        if (PAR_EN) begin
                            state_d = ST_PARITY;
                            txd_d   = par_bit;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        idx_d = idx_inc;
                        txd_d = data_q[idx_inc];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
            en_d0_q <= 1'b0;
            en_d1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            txd_q   <= txd_d;
            en_d0_q <= en_d0_d;
            en_d1_q <= en_d1_d;
        end
    end

    assign uart_txd     = txd_q;
    assign uart_tx_busy = busy_q;

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send with BPS_CNT = 10: one instance per parity mode, a table
// of frames with hand-computed line bits, and hand-written reset sequences.
module tb_uart_send;

    logic       clk = 1'b0;
    logic       sys_rst_n;
    logic       en_n, en_o, en_e;
    logic [7:0] din_n, din_o, din_e;
    logic       busy_n, busy_o, busy_e;
    logic       txd_n, txd_o, txd_e;

    always #5 clk = ~clk;

    uart_send #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .PARITY(0)) dut_n (
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .uart_en(en_n), .uart_din(din_n),
        .uart_tx_busy(busy_n), .uart_txd(txd_n));
    uart_send #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .PARITY(1)) dut_o (
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .uart_en(en_o), .uart_din(din_o),
        .uart_tx_busy(busy_o), .uart_txd(txd_o));
    uart_send #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .PARITY(2)) dut_e (
        .sys_clk(clk), .sys_rst_n(sys_rst_n), .uart_en(en_e), .uart_din(din_e),
        .uart_tx_busy(busy_e), .uart_txd(txd_e));

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          par;       // which instance: 0 none, 1 odd, 2 even
        logic [7:0]  din;
        logic [10:0] frame;     // expected line bits, bit 0 = start bit
        int          len;       // bits per frame
        bit          hold;      // keep uart_en high through the frame
        int          poke_at;   // cycle after acceptance to raise uart_en again, -1 none
        int          poke_len;
        bit          b2b;       // start immediately after the previous frame
        bit          rel_rst;   // release reset together with raising uart_en
        int          post_idle; // cycles the line must stay idle afterwards
    } vec_t;

    vec_t vecs[12];

    // Reference receiver on the no-parity line: samples mid-bit, stores {stop, data}.
    logic [8:0] rx_q[$];
    logic [8:0] rx_sh;

    always begin
        @(negedge txd_n);
        repeat (15) @(posedge clk);
        #1;
        rx_sh[0] = txd_n;
        for (int i = 1; i < 9; i++) begin
            repeat (10) @(posedge clk);
            #1;
            rx_sh[i] = txd_n;
        end
        rx_q.push_back(rx_sh);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int par, input logic en, input logic [7:0] d);
        case (par)
            1:       begin en_o = en; din_o = d; end
            2:       begin en_e = en; din_e = d; end
            default: begin en_n = en; din_n = d; end
        endcase
    endtask

    function automatic logic get_txd(input int par);
        case (par)
            1:       return txd_o;
            2:       return txd_e;
            default: return txd_n;
        endcase
    endfunction

    function automatic logic get_busy(input int par);
        case (par)
            1:       return busy_o;
            2:       return busy_e;
            default: return busy_n;
        endcase
    endfunction

    task automatic run_frame(input int vi);
        vec_t v;
        int   n_bad;
        v = vecs[vi];
        if (!v.b2b) begin
            repeat (2) @(posedge clk);
            #1;
        end
        set_in(v.par, 1'b1, v.din);
        if (v.rel_rst) sys_rst_n = 1'b1;
        @(posedge clk);
        #1;  // edge k: request sampled, not yet accepted
        chk($sformatf("v%0d_busy_at_k", vi), get_busy(v.par), 1'b0);
        chk($sformatf("v%0d_txd_at_k", vi), get_txd(v.par), 1'b1);
        @(posedge clk);
        #1;  // edge k+1: accepted
        chk($sformatf("v%0d_busy_at_k1", vi), get_busy(v.par), 1'b1);
        chk($sformatf("v%0d_txd_at_k1", vi), get_txd(v.par), 1'b0);
        set_in(v.par, v.hold, ~v.din);
        for (int c = 1; c <= v.len * 10; c++) begin
            @(posedge clk);
            #1;
            if (c == v.poke_at) set_in(v.par, 1'b1, 8'hFF);
            if (v.poke_at >= 0 && c == v.poke_at + v.poke_len) set_in(v.par, 1'b0, 8'hFF);
            if (c % 10 == 5)
                chk($sformatf("v%0d_bit%0d", vi, c / 10), get_txd(v.par), v.frame[c / 10]);
            if (c == v.len * 10 - 1)
                chk($sformatf("v%0d_busy_before_end", vi), get_busy(v.par), 1'b1);
        end
        chk($sformatf("v%0d_busy_end", vi), get_busy(v.par), 1'b0);
        chk($sformatf("v%0d_txd_end", vi), get_txd(v.par), 1'b1);
        n_bad = 0;
        for (int i = 0; i < v.post_idle; i++) begin
            @(posedge clk);
            #1;
            if (get_busy(v.par) !== 1'b0 || get_txd(v.par) !== 1'b1) n_bad++;
        end
        if (v.post_idle > 0) chk($sformatf("v%0d_post_idle_bad", vi), n_bad, 0);
        set_in(v.par, 1'b0, 8'h00);
    endtask

    initial begin
        int n_bad;
        int ri;

        //            par din    frame                               len hold poke pl b2b rr post
        vecs[0]  = '{0, 8'h55, {1'b0, 1'b1, 8'h55, 1'b0},           10, 0, -1,  0, 0, 0, 20};
        vecs[1]  = '{2, 8'h07, {1'b1, 1'b1, 8'h07, 1'b0},           11, 0, -1,  0, 0, 0, 20};
        vecs[2]  = '{1, 8'h07, {1'b1, 1'b0, 8'h07, 1'b0},           11, 0, -1,  0, 0, 0, 20};
        vecs[3]  = '{2, 8'h00, {1'b1, 1'b0, 8'h00, 1'b0},           11, 0, -1,  0, 0, 0, 10};
        vecs[4]  = '{1, 8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0},           11, 0, -1,  0, 0, 0, 10};
        vecs[5]  = '{2, 8'h96, {1'b1, 1'b0, 8'h96, 1'b0},           11, 0, -1,  0, 0, 0, 10};
        vecs[6]  = '{0, 8'hA3, {1'b0, 1'b1, 8'hA3, 1'b0},           10, 1, -1,  0, 0, 0, 200};
        vecs[7]  = '{0, 8'h3C, {1'b0, 1'b1, 8'h3C, 1'b0},           10, 0, 39,  3, 0, 0, 30};
        vecs[8]  = '{0, 8'hC5, {1'b0, 1'b1, 8'hC5, 1'b0},           10, 0, 98, 40, 0, 0, 30};
        vecs[9]  = '{0, 8'h01, {1'b0, 1'b1, 8'h01, 1'b0},           10, 0, -1,  0, 0, 0, 0};
        vecs[10] = '{0, 8'h80, {1'b0, 1'b1, 8'h80, 1'b0},           10, 0, -1,  0, 1, 0, 30};
        vecs[11] = '{0, 8'h5A, {1'b0, 1'b1, 8'h5A, 1'b0},           10, 1, -1,  0, 0, 1, 30};

        sys_rst_n = 1'b0;
        en_n = 1'b0; en_o = 1'b0; en_e = 1'b0;
        din_n = 8'h00; din_o = 8'h00; din_e = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd_n", txd_n, 1'b1);
        chk("rst_busy_n", busy_n, 1'b0);
        chk("rst_txd_o", txd_o, 1'b1);
        chk("rst_busy_o", busy_o, 1'b0);
        chk("rst_txd_e", txd_e, 1'b1);
        chk("rst_busy_e", busy_e, 1'b0);
        sys_rst_n = 1'b1;

        // Reset in the middle of data bit 3 aborts the frame at once.
        repeat (2) @(posedge clk);
        #1;
        en_n = 1'b1; din_n = 8'h55;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        en_n = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        chk("mid_bit3_txd", txd_n, 1'b0);
        chk("mid_bit3_busy", busy_n, 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("abort_txd", txd_n, 1'b1);
        chk("abort_busy", busy_n, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (busy_n !== 1'b0 || txd_n !== 1'b1) n_bad++;
        end
        chk("after_abort_idle_bad", n_bad, 0);
        rx_q.delete();

        for (int vi = 0; vi < 12; vi++) begin
            if (vecs[vi].rel_rst) begin
                sys_rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                chk($sformatf("v%0d_rst_txd", vi), txd_n, 1'b1);
                chk($sformatf("v%0d_rst_busy", vi), busy_n, 1'b0);
            end
            run_frame(vi);
        end

        repeat (5) @(posedge clk);
        #1;
        // Every no-parity frame must arrive at the receiver, in order, with a good stop bit.
        ri = 0;
        for (int vi = 0; vi < 12; vi++) begin
            if (vecs[vi].par == 0) begin
                if (ri < rx_q.size())
                    chk($sformatf("rx_frame%0d", ri), rx_q[ri], {1'b1, vecs[vi].din});
                ri++;
            end
        end
        chk("rx_count", rx_q.size(), ri);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
